// File: rtl/sdhci_cmd_sched.sv
// ============================================================================
// sdhci_cmd_sched : SDHCI command-line scheduler (driver / auto CMD12 / CMD23)
// Rev 1.0
// ============================================================================
`default_nettype none

module sdhci_cmd_sched #(
  parameter int N_GAP = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_en_p_i,
  input  logic       soft_rst_i,
  input  logic       drv_req_i,
  input  logic       drv_busy_i,
  input  logic       cmd12_req_i,
  input  logic       cmd23_req_i,
  input  logic       cmd_err_i,
  input  logic       acmd_err_i,
  input  logic       engine_ack_i,
  input  logic       cmd_done_i,
  output logic       start_o,
  output logic [1:0] sel_o,
  output logic       inhibit_cmd_o,
  output logic       inhibit_dat_o,
  output logic       cmd12_not_exec_o,
  output logic       cmd_not_issued_o
);

  localparam int CW     = (N_GAP > 0) ? $clog2(N_GAP + 1) : 1;
  localparam int LAST_I = (N_GAP > 0) ? N_GAP - 1 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_ACTIVE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend12_q, pend12_d;
  logic          pend23_q, pend23_d;
  logic          pendd_q, pendd_d;
  logic          inh_dat_q, inh_dat_d;
  logic          clr12, clr23, clrd;
  logic          drop12, dropd;
  logic          rst_any;

  assign rst_any = rst_i | soft_rst_i;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    clr12   = 1'b0;
    clr23   = 1'b0;
    clrd    = 1'b0;
    drop12  = 1'b0;
    dropd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only the highest-priority pending source is looked at per cycle.
        if (pend12_q) begin
          if (cmd_err_i) begin
            clr12  = 1'b1;
            drop12 = 1'b1;
          end else begin
            sel_d   = 2'd1;
            state_d = S_ISSUE;
          end
        end else if (pend23_q) begin
          sel_d   = 2'd2;
          state_d = S_ISSUE;
        end else if (pendd_q) begin
          if (acmd_err_i) begin
            clrd  = 1'b1;
            dropd = 1'b1;
          end else begin
            sel_d   = 2'd0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (engine_ack_i) begin
          case (sel_q)
            2'd1:    clr12 = 1'b1;
            2'd2:    clr23 = 1'b1;
            default: clrd  = 1'b1;
          endcase
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (cmd_done_i) begin
          cnt_d   = '0;
          state_d = (N_GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (clk_en_p_i) begin
          if (cnt_q == LAST) state_d = S_IDLE;
          else               cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request landing on the same cycle as its clear keeps the bit set.
    pend12_d = (pend12_q & ~clr12) | cmd12_req_i;
    pend23_d = (pend23_q & ~clr23) | cmd23_req_i;
    pendd_d  = (pendd_q  & ~clrd)  | drv_req_i;

    inh_dat_d = inh_dat_q;
    if (drv_req_i && drv_busy_i)
      inh_dat_d = 1'b1;
    else if (state_q == S_IDLE && !pend12_q && !pend23_q && !pendd_q && !drv_req_i)
      inh_dat_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_any) begin
      state_q   <= S_IDLE;
      sel_q     <= 2'd0;
      cnt_q     <= '0;
      pend12_q  <= 1'b0;
      pend23_q  <= 1'b0;
      pendd_q   <= 1'b0;
      inh_dat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      pend12_q  <= pend12_d;
      pend23_q  <= pend23_d;
      pendd_q   <= pendd_d;
      inh_dat_q <= inh_dat_d;
    end
  end

  assign start_o          = (state_q == S_ISSUE);
  assign sel_o            = sel_q;
  assign inhibit_dat_o    = inh_dat_q;
  assign inhibit_cmd_o    = ~rst_any & ((state_q != S_IDLE) | pend12_q | pend23_q |
                                        pendd_q | drv_req_i);
  assign cmd12_not_exec_o = ~rst_any & drop12;
  assign cmd_not_issued_o = ~rst_any & dropd;

endmodule

`default_nettype wire

// File: doc/sdhci_cmd_sched.md
# sdhci_cmd_sched

Command-line scheduler for the SDHCI host. It arbitrates between three command sources: the driver command write, auto CMD12 and auto CMD23. It issues one start request at a time to the command engine and enforces the command-to-command gap. It also owns the Command Inhibit (CMD) and Command Inhibit (DAT) flags and the auto-command skip reporting. It sits between the register file / data path request pulses and the command engine's start handshake.

## Interface
- N_GAP, default 8: number of sd_clk posedges held in GAP after a command completes; 0 bypasses GAP.
- clk_i  in  1  host clock; sole clock.
- rst_i  in  1  synchronous, active-high reset.
- clk_en_p_i  in  1  high in the clk_i cycle before an sd_clk posedge.
- soft_rst_i  in  1  CMD-line software reset; synchronous, same effect as rst_i on this block.
- drv_req_i  in  1  one-cycle pulse when the driver writes the command index.
- drv_busy_i  in  1  driver command expects R1b (busy); sampled with drv_req_i.
- cmd12_req_i  in  1  one-cycle pulse requesting auto CMD12.
- cmd23_req_i  in  1  one-cycle pulse requesting auto CMD23.
- cmd_err_i  in  1  OR of the command index / end-bit / CRC / timeout error status bits.
- acmd_err_i  in  1  OR of the auto CMD12/23 index / end-bit / CRC / timeout error status bits.
- engine_ack_i  in  1  command engine has accepted the start (left READY).
- cmd_done_i  in  1  one-cycle pulse when the engine returns to READY.
- start_o  out  1  start request to the engine; held until engine_ack_i.
- sel_o  out  2  source of the current command: 0 = driver, 1 = CMD12, 2 = CMD23; 3 is never driven.
- inhibit_cmd_o  out  1  Command Inhibit (CMD).
- inhibit_dat_o  out  1  Command Inhibit (DAT).
- cmd12_not_exec_o  out  1  one-cycle pulse: pending CMD12 was dropped.
- cmd_not_issued_o  out  1  one-cycle pulse: pending driver command was dropped.

## Operation
- **Reset.** rst_i or soft_rst_i forces:
  - state IDLE, all pending bits 0, GAP counter 0;
  - sel_o = 0, start_o = 0, inhibit_cmd_o = 0, inhibit_dat_o = 0, both pulse outputs 0.
  - Reset in any state aborts without waiting for engine_ack_i or cmd_done_i.
- **Pending bits.** pend12, pend23 and pendd are set by their request pulses and are sticky.
  - A repeated pulse while a bit is already set merges (no second command).
  - A pulse in the same cycle as that bit's clear leaves the bit set (set wins).
- **Priority in IDLE:** pend12 > pend23 > pendd. Only the highest pending source is evaluated each cycle.
  - pend12 with cmd_err_i = 1: clear pend12, pulse cmd12_not_exec_o, stay IDLE.
  - pendd with acmd_err_i = 1: clear pendd, pulse cmd_not_issued_o, stay IDLE.
  - pend23 is never dropped. An auto CMD23 failure blocks the following driver command through acmd_err_i.
  - Otherwise: latch sel_o to the selected source and go to ISSUE.
- **ISSUE.**
  - start_o = 1.
  - On engine_ack_i: clear the selected pending bit and go to ACTIVE.
- **ACTIVE.**
  - On cmd_done_i: go to GAP (or IDLE if N_GAP = 0) and clear the counter.
- **GAP.**
  - Counter increments on clk_en_p_i.
  - When count = N_GAP-1 and clk_en_p_i = 1: go to IDLE.
  - Counter width is $clog2(N_GAP+1).
- **Ignored inputs.** cmd_done_i outside ACTIVE and engine_ack_i outside ISSUE are ignored.
- **Command Inhibit (CMD).** inhibit_cmd_o = (state != IDLE) | pend12 | pend23 | pendd | drv_req_i.
- **Command Inhibit (DAT).**
  - Set on the cycle after drv_req_i & drv_busy_i.
  - Cleared the cycle after IDLE is reached with no pending bits and no drv_req_i.

## Timing
- Request pulse at cycle 0 → pending bit set at cycle 1 → IDLE decision at cycle 1 → start_o = 1 at cycle 2 (ISSUE is registered).
- Drop pulses are combinational in the decision cycle, exactly one cycle wide, and can occur at most once per cycle.
- engine_ack_i at cycle k → start_o = 0 and state ACTIVE at cycle k+1.
- cmd_done_i at cycle k → GAP at k+1. IDLE is reached on the cycle after the N_GAP-th clk_en_p_i counted in GAP.
- Back-to-back requests are fully serialized: CMD23 then the driver command each traverse ISSUE → ACTIVE → GAP.
- sel_o is stable from ISSUE entry through the end of GAP.
- All outputs are registered except inhibit_cmd_o and the two drop pulses.

## Test plan
- **Reset values.** Assert rst_i for 3 cycles in ACTIVE → next cycle all outputs 0, state IDLE; a later cmd_done_i has no effect.
- **Single driver command.** drv_req_i at t0 with drv_busy_i = 1:
  - start_o high at t2, sel_o = 0, inhibit_dat_o high from t1;
  - ack at t5, cmd_done_i at t20;
  - with N_GAP = 8 and clk_en_p_i every 4 cycles, inhibit_cmd_o falls 8 enables later and inhibit_dat_o one cycle after that.
- **Priority.** cmd23_req_i and drv_req_i in the same cycle → CMD23 issued first (sel_o = 2), driver second (sel_o = 0); cmd12_req_i arriving during CMD23's ACTIVE → CMD12 preempts the pending driver command.
- **Drop paths.**
  - pend12 with cmd_err_i = 1 → exactly one cmd12_not_exec_o pulse, no start_o, inhibit_cmd_o falls next cycle.
  - pendd with acmd_err_i = 1 → one cmd_not_issued_o pulse.
- **Collisions.** drv_req_i coincident with the engine_ack_i of a driver command → a second driver command is issued after GAP. A duplicate cmd12_req_i while pend12 is set → only one CMD12.
- **Boundaries.**
  - N_GAP = 0: IDLE on the cycle after cmd_done_i.
  - soft_rst_i while in ISSUE: start_o low next cycle, pending bits cleared.
